// File: rtl/prince_round_ctrl.sv
// Round controller and shared masked-state register for the round-based TI PRINCE core.
// Selects fresh vs. feedback shares at the input muxers and sequences the rounds.
module prince_round_ctrl #(
  parameter int SHARES = 4,
  parameter int WIDTH  = 64,
  parameter int ROUNDS = 12,
  parameter int LAT    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [SHARES*WIDTH-1:0]     mux_res,
  output logic                        sel,
  output logic [SHARES*WIDTH-1:0]     state,
  output logic [$clog2(ROUNDS)-1:0]   round_idx,
  output logic [1:0]                  phase,
  output logic                        busy,
  output logic                        done,
  input  logic                        ack,
  output logic [1:0]                  fsm_state
);

  localparam int IW  = $clog2(ROUNDS);
  localparam int CW  = ($clog2(LAT + 1) < 1) ? 1 : $clog2(LAT + 1);
  localparam int FWD = (ROUNDS - 2) / 2;
  localparam logic [IW-1:0] FWD_I  = IW'(FWD);
  localparam logic [IW-1:0] LAST_I = IW'(ROUNDS - 1);
  localparam logic [CW-1:0] BEAT_I = CW'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } st_t;

  st_t           cur, nxt;
  logic [CW-1:0] lat_cnt;
  logic          beat;
  logic          last_round;

  assign beat       = (lat_cnt == BEAT_I);
  assign last_round = (round_idx == LAST_I);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:  if (start) nxt = S_RUN;
      S_RUN:   if (beat && last_round) nxt = S_DONE;
      S_DONE:  if (ack) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs depend on the FSM state alone so sel never glitches with start/ack.
  always_comb begin
    sel       = (cur == S_IDLE);
    busy      = (cur == S_RUN);
    done      = (cur == S_DONE);
    fsm_state = cur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= '0;
      round_idx <= '0;
      lat_cnt   <= '0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (start) begin
            state     <= mux_res;
            round_idx <= '0;
            lat_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (beat) begin
            state   <= mux_res;
            lat_cnt <= '0;
            if (!last_round) round_idx <= round_idx + IW'(1);
          end else begin
            lat_cnt <= lat_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Middle phase covers the two rounds straddling the reflection.
  always_comb begin
    phase = 2'd2;
    if (round_idx < FWD_I)
      phase = 2'd0;
    else if ((round_idx == FWD_I) || (round_idx == FWD_I + IW'(1)))
      phase = 2'd1;
  end

endmodule

// File: tb/tb_prince_round_ctrl.sv
// Bench for prince_round_ctrl: a LAT=1 and a LAT=3 instance share clock, reset and mux_res.
// Final-state/latency expectations go through queues; a monitor pops them when done rises.
module tb_prince_round_ctrl;

  localparam int SHARES = 4;
  localparam int WIDTH  = 64;
  localparam int W      = SHARES * WIDTH;
  localparam int ROUNDS = 12;
  localparam int IW     = 4;

  localparam logic [1:0] PH_TAB [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1,
                                         2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};

  localparam logic [W-1:0] A1 = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                 64'h0f1e2d3c4b5a6978, 64'h8796a5b4c3d2e1f0};
  localparam logic [W-1:0] A2 = {64'hffffffffffffffff, 64'h0000000000000000,
                                 64'haaaaaaaaaaaaaaaa, 64'h5555555555555555};
  localparam logic [W-1:0] A3 = {64'h1111111111111111, 64'h2222222222222222,
                                 64'h3333333333333333, 64'h4444444444444444};
  localparam logic [W-1:0] A4 = {64'hdeadbeefcafef00d, 64'h0badc0de12345678,
                                 64'h0000000000000001, 64'h00000000000000f0};
  localparam logic [W-1:0] A5 = {64'h9e3779b97f4a7c15, 64'hf39cc0605cedc834,
                                 64'h1082276bf3a27251, 64'hf86c6a11d0c18e95};
  localparam logic [W-1:0] A6 = {64'h7777777777777777, 64'h8888888888888888,
                                 64'h9999999999999999, 64'h00000000000000aa};
  localparam logic [W-1:0] A7 = {64'h13579bdf02468ace, 64'hace02468bdf13579,
                                 64'h0000ffff0000ffff, 64'hffff0000ffff0000};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, start3, ack;
  logic [W-1:0]  mux_res;

  logic          sel, busy, done;
  logic [W-1:0]  state;
  logic [IW-1:0] round_idx;
  logic [1:0]    phase, fsm_state;

  logic          sel3, busy3, done3;
  logic [W-1:0]  state3;
  logic [IW-1:0] round_idx3;
  logic [1:0]    phase3, fsm_state3;

  prince_round_ctrl #(.SHARES(SHARES), .WIDTH(WIDTH), .ROUNDS(ROUNDS), .LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mux_res(mux_res), .sel(sel),
    .state(state), .round_idx(round_idx), .phase(phase), .busy(busy), .done(done),
    .ack(ack), .fsm_state(fsm_state)
  );

  prince_round_ctrl #(.SHARES(SHARES), .WIDTH(WIDTH), .ROUNDS(ROUNDS), .LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mux_res(mux_res), .sel(sel3),
    .state(state3), .round_idx(round_idx3), .phase(phase3), .busy(busy3), .done(done3),
    .ack(ack), .fsm_state(fsm_state3)
  );

  // scoreboard state
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp3_q[$];
  int           lat_q[$];
  int           lat3_q[$];
  logic [W-1:0] base = '0;
  int           ecount = 0;
  bit           run1 = 1'b0;
  bit           run3 = 1'b0;
  logic         pd1 = 1'b0;
  logic         pd3 = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // mux_res = base + (edges since start was driven); capture k of the LAT=1 unit sees A+k
  initial begin
    forever begin
      @(posedge clk);
      #2;
      ecount++;
      mux_res = base + W'(ecount);
    end
  end

  // per-cycle run checks
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && run1 && ecount >= 1 && ecount <= 12) begin
        check("busy_run", W'(busy), W'(1'b1));
        check("sel_run", W'(sel), W'(1'b0));
        check("round_idx", W'(round_idx), W'(ecount - 1));
        check("phase", W'(phase), W'(PH_TAB[ecount - 1]));
        check("state_run", state, base + W'(ecount - 1));
      end
      if (rst_n && run3 && ecount >= 1 && ecount <= 36) begin
        check("busy3_run", W'(busy3), W'(1'b1));
        check("state3_run", state3, base + W'(3 * ((ecount - 1) / 3)));
      end
    end
  end

  // done monitor: pops expected final state and latency
  initial begin
    forever begin
      @(negedge clk);
      if (done && !pd1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: actual done=1 required no pending run");
        end else begin
          check("final_state", state, exp_q.pop_front());
          check("latency", W'(ecount), W'(lat_q.pop_front()));
        end
        run1 = 1'b0;
      end
      if (done3 && !pd3) begin
        if (exp3_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done3: actual done=1 required no pending run");
        end else begin
          check("final_state3", state3, exp3_q.pop_front());
          check("latency3", W'(ecount), W'(lat3_q.pop_front()));
        end
        run3 = 1'b0;
      end
      pd1 = done;
      pd3 = done3;
    end
  end

  // driver tasks
  task automatic launch(input bit use3, input logic [W-1:0] a);
    @(negedge clk);
    base    = a;
    ecount  = 0;
    mux_res = a;
    if (use3) begin
      start3 = 1'b1; run3 = 1'b1;
      exp3_q.push_back(a + W'(36)); lat3_q.push_back(37);
    end else begin
      start = 1'b1; run1 = 1'b1;
      exp_q.push_back(a + W'(12)); lat_q.push_back(13);
    end
    @(negedge clk);
    start  = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input bit use3);
    int n = 0;
    while (!(use3 ? done3 : done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: actual no done after %0d cycles required done", n);
    end
  endtask

  task automatic do_ack();
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; ack = 1'b0; mux_res = '0;
    repeat (3) @(negedge clk);
    check("rst_sel", W'(sel), W'(1'b1));
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_done", W'(done), W'(1'b0));
    check("rst_state", state, '0);
    check("rst_round_idx", W'(round_idx), W'(0));
    check("rst_fsm", W'(fsm_state), W'(0));
    check("rst_sel3", W'(sel3), W'(1'b1));
    check("rst_state3", state3, '0);

    @(negedge clk);
    rst_n = 1'b1;
    base = A1;
    repeat (5) @(negedge clk);
    check("idle_state", state, '0);
    check("idle_sel", W'(sel), W'(1'b1));
    check("idle_busy", W'(busy), W'(1'b0));
    check("idle_round_idx", W'(round_idx), W'(0));
    check("idle_state3", state3, '0);

    // nominal run
    launch(1'b0, A1);
    wait_done(1'b0);
    do_ack();

    // handshake: hold in DONE, then ack together with start
    launch(1'b0, A2);
    wait_done(1'b0);
    repeat (20) begin
      @(negedge clk);
      check("hold_state", state, A2 + W'(12));
      check("hold_done", W'(done), W'(1'b1));
    end
    @(negedge clk); ack = 1'b1; start = 1'b1;
    @(negedge clk); ack = 1'b0; start = 1'b0;
    check("ackstart_busy", W'(busy), W'(1'b0));
    check("ackstart_done", W'(done), W'(1'b0));
    check("ackstart_sel", W'(sel), W'(1'b1));
    check("ackstart_state", state, A2 + W'(12));
    launch(1'b0, A3);
    wait_done(1'b0);
    do_ack();

    // start held high throughout RUN
    launch(1'b0, A4);
    begin
      int n = 0;
      while (!done && n < 100) begin
        start = 1'b1;
        @(negedge clk);
        n++;
      end
      start = 1'b0;
    end
    wait_done(1'b0);
    do_ack();

    // LAT = 3 instance
    launch(1'b1, A5);
    wait_done(1'b1);
    do_ack();

    // async reset mid-run at round 6
    launch(1'b0, A6);
    begin
      int n = 0;
      while (round_idx != IW'(6) && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        n_checks++; n_fail++;
        $display("FAIL reach_round6: actual round_idx %0d required 6", round_idx);
      end
    end
    #2;
    rst_n = 1'b0;
    run1  = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("arst_sel", W'(sel), W'(1'b1));
    check("arst_busy", W'(busy), W'(1'b0));
    check("arst_done", W'(done), W'(1'b0));
    check("arst_state", state, '0);
    check("arst_round_idx", W'(round_idx), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    launch(1'b0, A7);
    wait_done(1'b0);
    do_ack();

    repeat (2) @(negedge clk);
    check("exp_q_empty", W'(exp_q.size()), W'(0));
    check("exp3_q_empty", W'(exp3_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
